// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: access sizes, FSM states
// and requester selection.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_access_size_t;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_IF,
        BUSY_D,
        RESP_IF,
        RESP_D
    } arb_state_t;

    typedef enum logic {
        ARB_SEL_IF,
        ARB_SEL_D
    } arb_sel_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store. Data wins
// ties, but a saturating streak counter forces a fetch grant after MAX_DATA_STREAK.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_done_o,
    output logic [DATA_W-1:0] if_rd_data_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wr_data_i,
    input  mem_access_size_t  d_size_i,
    output logic              d_done_o,
    output logic [DATA_W-1:0] d_rd_data_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wr_data_o,
    output mem_access_size_t  mem_size_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rd_data_i
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [STREAK_W-1:0] streak;
    logic                txn_we;
    logic [ADDR_W-1:0]   txn_addr;
    logic [DATA_W-1:0]   txn_wr_data;
    mem_access_size_t    txn_size;
    logic [DATA_W-1:0]   rd_data_q;
    logic                any_req;
    arb_sel_t            sel;

    // Data has priority unless fetch has already yielded MAX_DATA_STREAK times in a row.
    function automatic arb_sel_t pick(input logic if_req, input logic d_req,
                                      input logic [STREAK_W-1:0] streak_cnt);
        if (d_req && !(if_req && streak_cnt == STREAK_MAX))
            return ARB_SEL_D;
        return ARB_SEL_IF;
    endfunction

    assign any_req = if_req_i | d_req_i;
    assign sel     = pick(if_req_i, d_req_i, streak);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = (sel == ARB_SEL_D) ? BUSY_D : BUSY_IF;
            BUSY_IF: if (mem_ack_i) state_nxt = RESP_IF;
            BUSY_D:  if (mem_ack_i) state_nxt = RESP_D;
            RESP_IF: state_nxt = IDLE;
            RESP_D:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o = 1'b0;
        if_done_o = 1'b0;
        d_done_o  = 1'b0;
        case (state)
            BUSY_IF, BUSY_D: mem_req_o = 1'b1;
            RESP_IF:         if_done_o = 1'b1;
            RESP_D:          d_done_o  = 1'b1;
            default:         ;
        endcase
    end

    // Transaction register, streak counter and captured read data.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            streak      <= '0;
            txn_we      <= 1'b0;
            txn_addr    <= '0;
            txn_wr_data <= '0;
            txn_size    <= WORD;
            rd_data_q   <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                if (sel == ARB_SEL_D) begin
                    txn_we      <= d_we_i;
                    txn_addr    <= d_addr_i;
                    txn_wr_data <= d_wr_data_i;
                    txn_size    <= d_size_i;
                    if (!if_req_i)
                        streak <= '0;
                    else if (streak != STREAK_MAX)
                        streak <= streak + 1'b1;
                end else begin
                    txn_we      <= 1'b0;
                    txn_addr    <= if_addr_i;
                    txn_wr_data <= '0;
                    txn_size    <= WORD;
                    streak      <= '0;
                end
            end
            if ((state == BUSY_IF || state == BUSY_D) && mem_ack_i)
                rd_data_q <= mem_rd_data_i;
        end
    end

    assign mem_we_o      = mem_req_o & txn_we;
    assign mem_addr_o    = txn_addr;
    assign mem_wr_data_o = txn_wr_data;
    assign mem_size_o    = txn_size;
    assign if_rd_data_o  = if_done_o ? rd_data_q : '0;
    assign d_rd_data_o   = d_done_o ? rd_data_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed fetch/store/reset cases
// plus randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int MAXS = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             if_req, if_done, d_req, d_we, d_done;
    logic [31:0]      if_addr, if_rd_data, d_addr, d_wr_data, d_rd_data;
    mem_access_size_t d_size, mem_size;
    logic             mem_req, mem_we, mem_ack;
    logic [31:0]      mem_addr, mem_wr_data, mem_rd_data;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(MAXS)) dut (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_done_o(if_done), .if_rd_data_o(if_rd_data),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wr_data_i(d_wr_data),
        .d_size_i(d_size), .d_done_o(d_done), .d_rd_data_o(d_rd_data),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wr_data_o(mem_wr_data), .mem_size_o(mem_size),
        .mem_ack_i(mem_ack), .mem_rd_data_i(mem_rd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 = port free, 1 = waiting on memory, 2 = responding.
    int               ph = 0;
    int               streak_m = 0;
    bit               m_is_d, m_we;
    logic [31:0]      m_addr, m_wdata, m_rdata;
    mem_access_size_t m_size;
    int               p_if, p_d, p_ack, p_spur;
    bit               prev_mem_req = 0;
    bit               obs_q[$];     // observed grants, 1 = data (addr bit 28 set)
    bit               pat[5] = '{1, 1, 1, 1, 0};

    task automatic check_outputs();
        check("mem_req", mem_req, ph == 1);
        check("if_done", if_done, ph == 2 && !m_is_d);
        check("d_done", d_done, ph == 2 && m_is_d);
        if (ph == 1) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_we", mem_we, m_we);
            check("mem_size", mem_size, m_size);
            if (m_we) check("mem_wr_data", mem_wr_data, m_wdata);
        end
        if (ph == 2 && !m_is_d) check("if_rd_data", if_rd_data, m_rdata);
        if (ph == 2 && m_is_d && !m_we) check("d_rd_data", d_rd_data, m_rdata);
        if (mem_req && !prev_mem_req) obs_q.push_back(mem_addr[28]);
        prev_mem_req = mem_req;
    endtask

    task automatic drive_and_advance();
        if (ph == 2 && !m_is_d) if_req = 1'b0;
        if (ph == 2 && m_is_d)  d_req  = 1'b0;
        if (!if_req) begin
            if_addr = $urandom & 32'h0FFF_FFFC;
            if ($urandom_range(99) < p_if) if_req = 1'b1;
        end
        if (!d_req) begin
            d_addr    = ($urandom & 32'h0FFF_FFFF) | 32'h1000_0000;
            d_we      = $urandom_range(1) == 1;
            d_wr_data = $urandom;
            case ($urandom_range(2))
                0:       d_size = BYTE;
                1:       d_size = HALF;
                default: d_size = WORD;
            endcase
            if ($urandom_range(99) < p_d) d_req = 1'b1;
        end
        mem_ack     = (ph == 1) ? ($urandom_range(99) < p_ack) : ($urandom_range(99) < p_spur);
        mem_rd_data = $urandom;
        case (ph)
            0: if (if_req || d_req) begin
                if (d_req && (!if_req || streak_m < MAXS)) begin
                    m_is_d = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wr_data; m_size = d_size;
                    streak_m = if_req ? ((streak_m + 1 > MAXS) ? MAXS : streak_m + 1) : 0;
                end else begin
                    m_is_d = 0; m_we = 0; m_addr = if_addr; m_wdata = 0; m_size = WORD;
                    streak_m = 0;
                end
                ph = 1;
            end
            1: if (mem_ack) begin m_rdata = mem_rd_data; ph = 2; end
            default: ph = 0;
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        drive_and_advance();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset = 1'b1; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        if_addr = 0; d_addr = 0; d_wr_data = 0; d_size = WORD; mem_rd_data = 0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wr_data", mem_wr_data, 0);
        check("rst_mem_size", mem_size, WORD);
        check("rst_done", {if_done, d_done}, 0);
        check("rst_rd_data", {if_rd_data, d_rd_data}, 0);
        reset = 1'b0;

        // Fetch only, ack held from IDLE (ignored) through first BUSY cycle.
        @(negedge clk);
        if_req = 1; if_addr = 32'h100; mem_ack = 1; mem_rd_data = 32'h13;
        @(negedge clk);
        check("f_req", mem_req, 1); check("f_addr", mem_addr, 32'h100);
        check("f_we", mem_we, 0); check("f_size", mem_size, WORD); check("f_done_early", if_done, 0);
        @(negedge clk);
        check("f_done", if_done, 1); check("f_data", if_rd_data, 32'h13); check("f_req_off", mem_req, 0);
        if_req = 0;
        @(negedge clk);
        check("f_done_once", if_done, 0); check("f_idle_ack", mem_req, 0);
        @(negedge clk);
        check("f_idle_stay", mem_req, 0);

        // Store with three memory wait cycles.
        d_req = 1; d_we = 1; d_addr = 32'h2004; d_wr_data = 32'hDEADBEEF; d_size = HALF; mem_ack = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("s_req", mem_req, 1); check("s_we", mem_we, 1); check("s_size", mem_size, HALF);
            check("s_addr", mem_addr, 32'h2004); check("s_wdata", mem_wr_data, 32'hDEADBEEF);
            check("s_done_early", d_done, 0);
            mem_ack = (i == 3);
        end
        @(negedge clk);
        check("s_done", d_done, 1); check("s_req_off", mem_req, 0);
        d_req = 0; mem_ack = 1;
        @(negedge clk);
        check("s_done_once", d_done, 0); check("s_resp_ack", mem_req, 0);
        mem_ack = 0;
        @(negedge clk);
        check("s_idle", {d_done, mem_req}, 0);

        // Both requesters continuously asserted, zero-wait memory.
        p_if = 100; p_d = 100; p_ack = 100; p_spur = 0;
        obs_q.delete();
        repeat (30) step();
        check("bb_count", obs_q.size(), 10);
        for (int i = 0; i < 10 && i < obs_q.size(); i++) check("bb_order", obs_q[i], pat[i % 5]);

        // Data-only traffic, then quiesce, then both together.
        p_if = 0; p_ack = 60; p_spur = 20;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (!if_req) begin obs_q.delete(); found = 1; end
        end
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (obs_q.size() >= 10) found = 1;
        end
        check("donly_reached", found, 1);
        foreach (obs_q[i]) check("donly_sel", obs_q[i], 1);
        p_d = 0; found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (!d_req && !if_req && ph == 0) found = 1;
        end
        check("quiesce", found, 1);
        p_if = 100; p_d = 100; obs_q.delete();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (obs_q.size() >= 5) found = 1;
        end
        check("mix_reached", found, 1);
        for (int i = 0; i < 5 && i < obs_q.size(); i++) check("mix_order", obs_q[i], pat[i]);

        // Randomized traffic with memory waits and stray acks.
        p_if = 40; p_d = 40; p_ack = 50; p_spur = 30;
        repeat (500) step();

        // Asynchronous reset mid data transaction with a nonzero streak.
        p_if = 100; p_d = 100; p_ack = 40; p_spur = 0; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (ph == 1 && m_is_d && streak_m >= 2) found = 1;
        end
        check("rst_setup", found, 1);
        @(posedge clk); #2;
        check("pre_rst_busy", mem_req, 1);
        reset = 1'b1;
        #1;
        check("arst_req", mem_req, 0);
        check("arst_we", mem_we, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_size", mem_size, WORD);
        @(negedge clk);
        check("arst_no_done", {d_done, if_done}, 0);
        check("arst_hold", mem_req, 0);
        reset = 1'b0; mem_ack = 0;
        ph = 0; streak_m = 0; prev_mem_req = 0; obs_q.delete();
        drive_and_advance();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (obs_q.size() >= 5) found = 1;
        end
        check("post_rst_reached", found, 1);
        for (int i = 0; i < 5 && i < obs_q.size(); i++) check("post_rst_order", obs_q[i], pat[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch requester and the load/store (data) requester. Data is served first, but a bounded streak counter guarantees fetch forward progress. Each granted request is latched, held on the memory port until acknowledged, and the read data is returned on a registered one-cycle response. The block sits between the multicycle control/datapath and the memory model, in place of the PC/ALU-out address mux.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DATA_STREAK, 4, number of consecutive data grants allowed while fetch is pending (must be ≥1)

Ports:
- clk_i  in  1  clock; one clock domain, all logic on posedge
- reset_i  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request, held until if_done_o
- if_addr_i  in  ADDR_W  fetch address (word read)
- if_done_o  out  1  one-cycle fetch completion pulse
- if_rd_data_o  out  DATA_W  fetch data, valid with if_done_o
- d_req_i  in  1  data request, held until d_done_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data address
- d_wr_data_i  in  DATA_W  store data
- d_size_i  in  mem_access_size_t  BYTE/HALF/WORD
- d_done_o  out  1  one-cycle data completion pulse
- d_rd_data_o  out  DATA_W  load data, valid with d_done_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wr_data_o  out  DATA_W  memory write data
- mem_size_o  out  mem_access_size_t  access size
- mem_ack_i  in  1  memory completion; read data is valid in the same cycle
- mem_rd_data_i  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_D, RESP_IF, RESP_D.
- IDLE: sample requests and arbitrate.
  - Neither pending: stay in IDLE.
  - Only one pending: grant it.
  - Both pending: grant data unless streak == MAX_DATA_STREAK, in which case grant fetch.
- On grant, latch the request fields into the transaction register and enter BUSY_x.
- Fetch transactions drive we=0 and size=WORD.
- BUSY_x:
  - mem_req_o=1; mem_* outputs come only from the latched fields.
  - Requester inputs are ignored.
  - On mem_ack_i: capture mem_rd_data_i and go to RESP_x. Otherwise stay.
- RESP_x: x_done_o=1 and x_rd_data_o = captured data for exactly one cycle, then IDLE.
  - Store completions also pulse d_done_o; d_rd_data_o is don't-care.
- Streak counter (width clog2(MAX_DATA_STREAK+1)):
  - Data grant while if_req_i=1: increment, saturating at MAX_DATA_STREAK.
  - Data grant while if_req_i=0: clear to 0.
  - Any fetch grant: clear to 0.
- Requesters may change or drop req in the cycle after their done pulse. Requests are sampled only in IDLE, so a new request placed immediately is seen in the next IDLE.
- mem_ack_i outside BUSY_x is ignored.
- Reset (asynchronous, any time, including mid-transaction):
  - state=IDLE, streak=0.
  - All outputs 0: mem_req_o, mem_we_o, mem_addr_o, mem_wr_data_o, done pulses, rd_data outputs; mem_size_o=WORD.
  - An in-flight transaction is abandoned with no done pulse.

## Timing
- Minimum transaction: 3 cycles (IDLE grant, BUSY with ack, RESP). Each extra memory wait cycle adds one.
- A request asserted in cycle t (state IDLE) sees mem_req_o=1 in t+1 and done no earlier than t+2.
- All outputs are registered or decoded from state; there is no combinational path from req_i or mem_ack_i to any output.
- Back-to-back requests from one requester: throughput of one transaction per 3 cycles (zero-wait memory).

## Structure
- Add to the definitions package:
  - arb_state_t enum (IDLE, BUSY_IF, BUSY_D, RESP_IF, RESP_D).
  - arb_sel_t (ARB_SEL_IF, ARB_SEL_D).
- Reuse mem_access_size_t from the definitions package.
- Single flat module with no sub-module. The priority decision is a local function, pick(if_req, d_req, streak).

## Test plan
- Fetch only, addr 0x100, ack on first BUSY cycle with data 0x00000013 -> mem_req_o high for 1 cycle; if_done_o pulses 2 cycles after the IDLE grant with if_rd_data_o=0x00000013.
- Data store addr 0x2004, data 0xDEADBEEF, size HALF, ack after 3 wait cycles -> mem_we_o=1, mem_size_o=HALF, mem_addr_o stable for 4 cycles; d_done_o pulses once; total 6 cycles.
- Both requesters continuously asserted, MAX_DATA_STREAK=4, zero-wait memory -> grant order D,D,D,D,IF,D,D,D,D,IF...
- Data only for 10 transactions, then fetch and data together -> streak stays 0, so data wins first; fetch is granted within at most 4 data transactions.
- Async reset asserted mid-BUSY_D between clock edges -> mem_req_o falls immediately; no d_done_o; after release, the first grant occurs from IDLE with streak=0.
- mem_ack_i pulsed in IDLE and RESP -> ignored: no state change and no extra done pulses.
